debounce_multi: RTL

//   N-channel push-button conditioner, successor to the single-channel 4-tap debouncer.
//   Per channel: DEPTH-tap sampling window with hysteresis, a registered debounced level,
//   one-cycle rise/fall pulses, and long-press detection with optional auto-repeat.

---
 rtl/debounce_multi.sv | 138 +++++++++++++
 1 files changed

// File: rtl/debounce_multi.sv
// debounce_multi: N-channel push-button conditioner.
// Each channel has a DEPTH-sample window with hysteresis, a registered
// debounced level, rise/fall pulses, and a long-press / auto-repeat pulse.
// Raw inputs must already be synchronous to clk_d.

module debounce_lane #(
    parameter int DEPTH         = 4,
    parameter int HOLD_CYCLES   = 8,
    parameter int REPEAT_CYCLES = 4,
    parameter int REPEAT_EN     = 1,
    parameter int CNT_W         = 16
) (
    input  logic clk_d,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall,
    output logic long_p
);
    typedef enum logic [1:0] {S_IDLE, S_HOLD, S_REPEAT, S_DONE} state_t;

    localparam logic [CNT_W-1:0] HOLD_C = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] REP_C  = CNT_W'(REPEAT_CYCLES);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

    logic [DEPTH-1:0] win;
    logic             level_next;
    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;

    // Hysteresis: only a unanimous window changes the level.
    always_comb begin
        level_next = level;
        if (&win)
            level_next = 1'b1;
        else if (~|win)
            level_next = 1'b0;
    end

    // Sample window, registered level and its edge pulses.
    always_ff @(posedge clk_d or posedge rst) begin
        if (rst) begin
            win   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            win   <= {win[DEPTH-2:0], raw};
            level <= level_next;
            rise  <= level_next & ~level;
            fall  <= ~level_next & level;
        end
    end

    // Hold FSM state and counter registers.
    always_ff @(posedge clk_d or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Hold FSM: counter restarts at 1 on each threshold hit so it never wraps;
    // a release always forces IDLE and masks any pulse in that cycle.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        long_p   = 1'b0;
        if (!level_next) begin
            state_nx = S_IDLE;
            cnt_nx   = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    state_nx = S_HOLD;
                    cnt_nx   = ONE;
                end
                S_HOLD: begin
                    if (cnt == HOLD_C) begin
                        long_p   = 1'b1;
                        cnt_nx   = ONE;
                        state_nx = (REPEAT_EN != 0) ? S_REPEAT : S_DONE;
                    end else begin
                        cnt_nx = cnt + ONE;
                    end
                end
                S_REPEAT: begin
                    if (cnt == REP_C) begin
                        long_p = 1'b1;
                        cnt_nx = ONE;
                    end else begin
                        cnt_nx = cnt + ONE;
                    end
                end
                default: begin
                    state_nx = S_DONE;
                    cnt_nx   = '0;
                end
            endcase
        end
    end
endmodule

module debounce_multi #(
    parameter int N_CH          = 2,
    parameter int DEPTH         = 4,
    parameter int HOLD_CYCLES   = 8,
    parameter int REPEAT_CYCLES = 4,
    parameter int REPEAT_EN     = 1,
    parameter int CNT_W         = 16
) (
    input  logic            clk_d,
    input  logic            rst,
    input  logic [N_CH-1:0] pb_raw,
    output logic [N_CH-1:0] pb_level,
    output logic [N_CH-1:0] pb_rise,
    output logic [N_CH-1:0] pb_fall,
    output logic [N_CH-1:0] pb_long
);
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        debounce_lane #(
            .DEPTH(DEPTH), .HOLD_CYCLES(HOLD_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES),
            .REPEAT_EN(REPEAT_EN), .CNT_W(CNT_W)
        ) u_lane (
            .clk_d  (clk_d),
            .rst    (rst),
            .raw    (pb_raw[i]),
            .level  (pb_level[i]),
            .rise   (pb_rise[i]),
            .fall   (pb_fall[i]),
            .long_p (pb_long[i])
        );
    end
endmodule
